// File: rtl/hs_fifo_pkt_len_chk.sv
// -----------------------------------------------------------------------------
// hs_fifo_pkt_len_chk
//
// Packet admission stage placed directly in front of an async FIFO write port,
// on the source-clock side. Beats pass through a single registered slice. Each
// packet's beats are counted. Packets that are too short, too long, or that
// carry an errored beat are closed with m_drop=1 on their last beat, so the
// FIFO discards the whole packet. A packet never puts more than MAX_PKT_LEN
// beats into the FIFO. Once the limit is reached, the rest of the packet is
// swallowed here.
//
// Ports
//   clk       : clock
//   aresetn   : asynchronous active-low reset
//   s_valid   : upstream beat valid
//   s_ready   : upstream beat ready
//   s_data    : upstream beat data      [DATA_WIDTH]
//   s_last    : upstream last beat of packet
//   s_err     : upstream beat error (packet must be dropped)
//   m_valid   : beat valid toward FIFO
//   m_ready   : FIFO ready
//   m_data    : beat data               [DATA_WIDTH]
//   m_last    : last beat of packet
//   m_drop    : with m_last, FIFO discards the whole packet
//   pkt_cnt   : packets delivered clean, saturating   [CNT_WIDTH]
//   drop_cnt  : packets closed with drop, saturating  [CNT_WIDTH]
// -----------------------------------------------------------------------------
module hs_fifo_pkt_len_chk #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 16,
  parameter int MIN_PKT_LEN = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_drop,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  // The beat index runs up to MAX_PKT_LEN. The width leaves headroom, so
  // count+1 never wraps.
  localparam int BW = $clog2(MAX_PKT_LEN + 2);
  localparam logic [BW-1:0] MAX_N = BW'(MAX_PKT_LEN);
  localparam logic [BW-1:0] MIN_N = BW'(MIN_PKT_LEN);

  typedef enum logic {
    ST_PASS    = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t                state_q,    state_d;
  logic [BW-1:0]         count_q,    count_d;
  logic                  sticky_q,   sticky_d;
  logic                  m_valid_q,  m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q,   m_data_d;
  logic                  m_last_q,   m_last_d;
  logic                  m_drop_q,   m_drop_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q,  pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic          slice_load;
  logic          accept;
  logic          out_fire;
  logic [BW-1:0] beat_n;
  logic          err_now;

  // The slice can take a new beat when it is empty or its beat leaves this cycle.
  assign slice_load = !m_valid_q || m_ready;

  // While discarding, beats never reach the slice, so upstream is never
  // back-pressured. This holds even if the closing overflow beat is still
  // stalled in the slice.
  assign s_ready  = (state_q == ST_DISCARD) ? 1'b1 : slice_load;
  assign accept   = s_valid && s_ready;
  assign out_fire = m_valid_q && m_ready;
  assign beat_n   = count_q + BW'(1);
  assign err_now  = sticky_q || s_err;

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, beat counter, output slice
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sticky_d  = sticky_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_drop_d  = m_drop_q;

    // The slice empties once its beat has left. A PASS-state accept below
    // refills it in the same cycle, which gives full throughput.
    if (slice_load) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_PASS: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          if (s_last) begin
            // A legal last beat at exactly MAX_PKT_LEN also lands here.
            m_last_d = 1'b1;
            m_drop_d = err_now || (beat_n < MIN_N);
            count_d  = '0;
            sticky_d = 1'b0;
          end else if (beat_n == MAX_N) begin
            // Overflow: close the packet as dropped and swallow its tail.
            m_last_d = 1'b1;
            m_drop_d = 1'b1;
            count_d  = '0;
            sticky_d = 1'b0;
            state_d  = ST_DISCARD;
          end else begin
            m_last_d = 1'b0;
            m_drop_d = 1'b0;
            count_d  = beat_n;
            sticky_d = err_now;
          end
        end
      end

      ST_DISCARD: begin
        // Errors on swallowed beats do not matter. The drop is already signalled.
        if (accept && s_last) begin
          state_d = ST_PASS;
        end
      end

      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Statistics: a packet is counted when its last beat is handed to the FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (out_fire && m_last_q) begin
      if (m_drop_q) begin
        if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
      end else begin
        if (pkt_cnt_q != {CNT_WIDTH{1'b1}}) begin
          pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_PASS;
      count_q    <= '0;
      sticky_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_drop_q   <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_drop_q   <= m_drop_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign m_drop   = m_drop_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/hs_fifo_pkt_len_chk.md
Name: hs_fifo_pkt_len_chk

Overview:
- Packet admission stage on the source-clock side, directly upstream of the async FIFO write port.
- Forwards a valid/ready beat stream through a registered slice and counts beats per packet.
- Marks packets that are too short, too long, or carry a beat error with the drop qualifier, so the FIFO discards them.
- Never emits more than MAX_PKT_LEN beats per packet, which bounds FIFO occupancy per packet.

Parameters:
- DATA_WIDTH, 32, width of s_data/m_data.
- MAX_PKT_LEN, 16, maximum legal beats per packet (>=1).
- MIN_PKT_LEN, 1, minimum legal beats per packet (1..MAX_PKT_LEN).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  clock.
- aresetn  input  1  reset; asynchronous, active-low.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  upstream beat ready.
- s_data  input  DATA_WIDTH  upstream beat data.
- s_last  input  1  last beat of packet.
- s_err  input  1  beat carries an error; packet must be dropped.
- m_valid  output  1  beat valid toward FIFO write port.
- m_ready  input  1  FIFO ready.
- m_data  output  DATA_WIDTH  beat data.
- m_last  output  1  last beat of packet.
- m_drop  output  1  with m_last: FIFO discards the whole packet, including this beat.
- pkt_cnt  output  CNT_WIDTH  packets delivered without drop, saturating.
- drop_cnt  output  CNT_WIDTH  packets terminated with m_drop, saturating.

Behaviour:
- Reset values: m_valid, m_last, m_drop = 0; m_data = 0; pkt_cnt, drop_cnt = 0; state = PASS; beat count = 0; sticky error = 0.
- Output register:
  - Slice is loaded when m_valid=0 or m_ready=1.
  - m_* hold stable while m_valid=1 and m_ready=0.
  - Latency is 1 cycle; full throughput with no bubbles.
- s_ready:
  - PASS: s_ready = !m_valid || m_ready.
  - DISCARD: s_ready = 1, and m_valid is not loaded.
- Accepted beat: s_valid && s_ready. Beat index n = count+1, computed with width clog2(MAX_PKT_LEN+2).
- State PASS, on an accepted beat:
  - err_now = sticky error OR s_err.
  - If s_last: emit beat with m_last=1.
    - m_drop = err_now OR (n < MIN_PKT_LEN).
    - Then clear count and sticky error; stay in PASS.
  - Else if n == MAX_PKT_LEN: emit beat with m_last=1, m_drop=1.
    - Clear count and sticky error; go to DISCARD.
  - Else: emit beat with m_last=0, m_drop=0; count = n; sticky error |= s_err.
- Overflow and s_last together:
  - A beat with s_last=1 and n == MAX_PKT_LEN is legal and follows the s_last rule (no drop unless there is an error).
  - An overflow beat is never last at input, so DISCARD is always entered after it.
- State DISCARD:
  - Accepted beats are swallowed; s_err is ignored.
  - On an accepted beat with s_last=1, go to PASS.
- m_drop is only ever 1 together with m_last=1.
- Counters update when a beat with m_last=1 leaves (m_valid && m_ready):
  - pkt_cnt += 1 if m_drop=0.
  - drop_cnt += 1 if m_drop=1.
  - Both saturate at all-ones.
- Reset mid-packet: everything returns to reset values immediately and any partial packet is abandoned. The FIFO write side must be reset together with this block.
- m_valid is never deasserted without a handshake. m_data/m_last/m_drop are stable while stalled, which satisfies the FIFO hold assertion.

Test Plan:
- MAX=16, MIN=1, 4-beat packet, no error, m_ready=1 -> 4 beats out one cycle after input; beat 4 has m_last=1, m_drop=0; pkt_cnt=1, drop_cnt=0.
- MIN=2, 1-beat packet -> single beat out with m_last=1, m_drop=1; drop_cnt=1.
- MAX=16, 20-beat packet -> 16 beats out, the 16th with m_last=1, m_drop=1; input beats 17-20 accepted with s_ready=1 and no output; the next 3-beat packet passes with m_drop=0.
- Exactly 16 beats with s_last on the 16th -> no drop, state stays PASS, pkt_cnt increments.
- 5-beat packet with s_err=1 on beat 2 -> 5 beats out; beat 5 has m_last=1, m_drop=1; the following clean packet has m_drop=0.
- m_ready=0 for 3 cycles mid-packet -> m_data/m_last stable, s_ready=0, no beat lost or duplicated. aresetn asserted mid-packet -> m_valid=0 and counters=0 in the same cycle.
